// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, FSM states, PC-select constant.
// Imported by the forwarding sub-module, the interface and the top.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } haz_state_e;

  localparam int PCSRC_SEQ = 0;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle; perf counter outputs exist only with HAZ_PERF_CNT_EN.
// master = pipeline datapath side, slave = hazard_ctrl_unit side.
interface hazard_ctrl_unit_if #(
  parameter int REG_W   = 5,
  parameter int PCSRC_W = 2,
  parameter int CNT_W   = 32
);
  import hazard_pkg::*;

  logic [PCSRC_W-1:0] PCSrcE;
  logic [REG_W-1:0]   Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic               LoadE, RegWriteM, RegWriteW, MemBusyM;
  logic               StallF, StallD, StallE, StallM, FlushD, FlushE;
  fwd_sel_e           ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]   StallCnt, FlushCnt;
`endif

  modport master (
    output PCSrcE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output LoadE, RegWriteM, RegWriteW, MemBusyM,
`ifdef HAZ_PERF_CNT_EN
    input  StallCnt, FlushCnt,
`endif
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  PCSrcE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  LoadE, RegWriteM, RegWriteW, MemBusyM,
`ifdef HAZ_PERF_CNT_EN
    output StallCnt, FlushCnt,
`endif
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE
  );

endinterface

// File: rtl/hazard_ctrl_unit_fwd.sv
// E-stage operand forwarding select for one source register; purely combinational.
// M-stage result takes precedence over W; x0 is never forwarded.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_we_m,
  input  logic             i_we_w,
  output fwd_sel_e         o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_rs != '0) begin
      if (i_we_m && (i_rd_m == i_rs))      o_fwd = FWD_M;
      else if (i_we_w && (i_rd_w == i_rs)) o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// RV32I hazard controller: load-use stall, memory-wait FSM, multi-cycle redirect flush window, forwarding.
// Optional perf counters (StallCnt/FlushCnt) are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int PCSRC_W      = 2,
  parameter int REDIRECT_LAT = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_unit_if.slave hz
);

  localparam int RCNT_W = 3;

  haz_state_e        r_state;
  logic [RCNT_W-1:0] r_redir_cnt;

  logic w_mem_stall, w_redirect, w_load_use, w_window;
  logic w_stall_fd, w_flush_d, w_flush_e;
  fwd_sel_e w_fwd_a, w_fwd_b;

  forward_unit #(.REG_W(REG_W)) u_fwd_a (
    .i_rs(hz.Rs1E), .i_rd_m(hz.RdM), .i_rd_w(hz.RdW),
    .i_we_m(hz.RegWriteM), .i_we_w(hz.RegWriteW), .o_fwd(w_fwd_a)
  );

  forward_unit #(.REG_W(REG_W)) u_fwd_b (
    .i_rs(hz.Rs2E), .i_rd_m(hz.RdM), .i_rd_w(hz.RdW),
    .i_we_m(hz.RegWriteM), .i_we_w(hz.RegWriteW), .o_fwd(w_fwd_b)
  );

  // Busy is seen combinationally, so the cycle busy drops already behaves as RUN.
  assign w_mem_stall = hz.MemBusyM;
  assign w_redirect  = !w_mem_stall && (hz.PCSrcE != PCSRC_W'(PCSRC_SEQ));
  assign w_load_use  = !w_mem_stall && hz.LoadE && (hz.RdE != '0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_window    = !w_mem_stall && (r_redir_cnt != '0);

  assign w_stall_fd = w_mem_stall || (w_load_use && !w_redirect);
  assign w_flush_d  = w_redirect || w_window;
  assign w_flush_e  = w_redirect || w_load_use;

  // Outputs are forced low while reset is held, independent of the inputs.
  assign hz.StallF    = !rst && w_stall_fd;
  assign hz.StallD    = !rst && w_stall_fd;
  assign hz.StallE    = !rst && w_mem_stall;
  assign hz.StallM    = !rst && w_mem_stall;
  assign hz.FlushD    = !rst && w_flush_d;
  assign hz.FlushE    = !rst && w_flush_e;
  assign hz.ForwardAE = rst ? FWD_RF : w_fwd_a;
  assign hz.ForwardBE = rst ? FWD_RF : w_fwd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_redir_cnt <= '0;
    end else begin
      case (r_state)
        RUN:      if (hz.MemBusyM)  r_state <= MEM_WAIT;
        MEM_WAIT: if (!hz.MemBusyM) r_state <= RUN;
        default:  r_state <= RUN;
      endcase
      // The window tracks fetch-pipeline depth, so it only drains when fetch advances.
      if (w_redirect)
        r_redir_cnt <= RCNT_W'(REDIRECT_LAT - 1);
      else if ((r_redir_cnt != '0) && !w_stall_fd)
        r_redir_cnt <= r_redir_cnt - RCNT_W'(1);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (hz.StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (hz.FlushE && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCnt = r_stall_cnt;
  assign hz.FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit with a 3-cycle redirect window.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_W(5), .PCSRC_W(2), .CNT_W(32)) hz ();

  hazard_ctrl_unit #(.REG_W(5), .PCSRC_W(2), .REDIRECT_LAT(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(hz.slave)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [5:0] ctl;
  assign ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};

  task automatic clear_inputs();
    hz.PCSrcE = '0; hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.LoadE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.MemBusyM = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs checked mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic [5:0] exp);
    #1;
    n_total++;
    if (ctl !== exp) $display("FAIL %s: ctl=%b expected %b", name, ctl, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_inputs();
    hz.MemBusyM = 1'b1;
    #3;
    n_total++;
    if ({ctl, hz.ForwardAE, hz.ForwardBE} !== 10'b0) $display("FAIL reset_outputs: got %b expected 0", {ctl, hz.ForwardAE, hz.ForwardBE});
    else n_pass++;
    hz.MemBusyM = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    chk_ctl("reset_idle", 6'b000000);
  endtask

  task automatic test_load_use();
    hz.LoadE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
    chk_ctl("load_use_stall", 6'b110001);
    next_cycle();
    hz.LoadE = 1'b0; hz.RdE = 5'd0;
    chk_ctl("load_use_one_cycle", 6'b000000);
    next_cycle();
    hz.LoadE = 1'b1; hz.Rs2D = 5'd7; hz.RdE = 5'd7; hz.Rs1D = 5'd1;
    chk_ctl("load_use_rs2", 6'b110001);
    next_cycle();
    hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
    chk_ctl("load_use_x0", 6'b000000);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_forward();
    hz.RdM = 5'd3; hz.RegWriteM = 1'b1; hz.RdW = 5'd3; hz.RegWriteW = 1'b1;
    hz.Rs1E = 5'd3; hz.Rs2E = 5'd3;
    #1;
    n_total++;
    if (hz.ForwardAE !== 2'b10) $display("FAIL fwd_a_m: got %b expected 10", hz.ForwardAE);
    else n_pass++;
    n_total++;
    if (hz.ForwardBE !== 2'b10) $display("FAIL fwd_b_m: got %b expected 10", hz.ForwardBE);
    else n_pass++;
    hz.RegWriteM = 1'b0;
    #1;
    n_total++;
    if (hz.ForwardAE !== 2'b01) $display("FAIL fwd_a_w: got %b expected 01", hz.ForwardAE);
    else n_pass++;
    hz.Rs1E = 5'd0; hz.RdW = 5'd0; hz.RdM = 5'd0; hz.RegWriteM = 1'b1;
    #1;
    n_total++;
    if (hz.ForwardAE !== 2'b00) $display("FAIL fwd_a_x0: got %b expected 00", hz.ForwardAE);
    else n_pass++;
    hz.Rs2E = 5'd9; hz.RdM = 5'd4; hz.RdW = 5'd9; hz.RegWriteW = 1'b0;
    #1;
    n_total++;
    if (hz.ForwardBE !== 2'b00) $display("FAIL fwd_b_nowe: got %b expected 00", hz.ForwardBE);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_redirect(input logic [1:0] sel);
    hz.PCSrcE = sel;
    chk_ctl($sformatf("redirect%0d_c0", sel), 6'b000011);
    next_cycle();
    hz.PCSrcE = 2'b00;
    chk_ctl($sformatf("redirect%0d_c1", sel), 6'b000010);
    next_cycle();
    chk_ctl($sformatf("redirect%0d_c2", sel), 6'b000010);
    next_cycle();
    chk_ctl($sformatf("redirect%0d_c3", sel), 6'b000000);
    next_cycle();
  endtask

  task automatic test_mem_wait();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    next_cycle();
    hz.PCSrcE = 2'b01;
    for (int i = 0; i < 4; i++) begin
      hz.MemBusyM = 1'b1;
      chk_ctl($sformatf("mem_wait_c%0d", i), 6'b111100);
      next_cycle();
    end
    hz.MemBusyM = 1'b0;
    chk_ctl("mem_wait_release", 6'b000011);
`ifdef HAZ_PERF_CNT_EN
    next_cycle();
    n_total++;
    if (hz.StallCnt !== 32'd4) $display("FAIL stall_cnt: got %0d expected 4", hz.StallCnt);
    else n_pass++;
    n_total++;
    if (hz.FlushCnt !== 32'd1) $display("FAIL flush_cnt: got %0d expected 1", hz.FlushCnt);
    else n_pass++;
`endif
    clear_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_priority();
    hz.LoadE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5; hz.PCSrcE = 2'b01;
    chk_ctl("redirect_over_load_use", 6'b000011);
    next_cycle();
    clear_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_mid();
    hz.PCSrcE = 2'b10;
    next_cycle();
    hz.PCSrcE = 2'b00;
    chk_ctl("window_before_rst", 6'b000010);
    rst = 1'b1;
    chk_ctl("rst_mid_window", 6'b000000);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    chk_ctl("window_discarded", 6'b000000);
    hz.MemBusyM = 1'b1;
    chk_ctl("mem_wait_before_rst", 6'b111100);
    hz.RdM = 5'd2; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd2;
    rst = 1'b1;
    chk_ctl("rst_mid_mem_wait", 6'b000000);
    n_total++;
    if (hz.ForwardAE !== 2'b00) $display("FAIL rst_fwd: got %b expected 00", hz.ForwardAE);
    else n_pass++;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    chk_ctl("after_rst_idle", 6'b000000);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_redirect(2'b01);
    test_redirect(2'b10);
    test_mem_wait();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
